fft_rd_engine: RTL

- Read-fetch stage directly upstream of the FFT datapath.
- On a start pulse from the control register logic, it takes a host buffer (byte address, byte size) from the HardCloud buffer registers.
- It issues one CCI-P-style cache-line read per 64-byte line, respecting channel and downstream backpressure plus an outstanding-request limit.
- It forwards each returned 512-bit block, tagged with its line index, to the consumer; it pulses done once every issued line has returned.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_rd_engine.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT host-fetch path: buffer addressing,
// 512-bit block type and read-engine state encoding.
package fft_pkg;

  localparam int unsigned CL_BYTES  = 64;
  localparam int unsigned CL_ADDR_W = 42;
  localparam int unsigned LINES_W   = 27;

  typedef logic [63:0]            t_hc_address;
  typedef logic [511:0]           t_block;
  typedef logic [CL_ADDR_W-1:0]   t_cl_addr;

  typedef enum logic [1:0] {
    S_RD_IDLE,
    S_RD_FETCH,
    S_RD_WAIT,
    S_RD_FINISH
  } t_rd_state;

  // Byte size to cache-line count, rounded up; 33-bit sum keeps 0xFFFFFFFF exact.
  function automatic logic [LINES_W-1:0] hc_size_to_lines(input logic [31:0] size);
    logic [32:0] rounded;
    rounded = {1'b0, size} + 33'(CL_BYTES - 1);
    return rounded[32:6];
  endfunction

endpackage

// File: rtl/fft_rd_engine.sv
// Read-fetch engine: issues one cache-line read per 64B line of a host buffer,
// bounded by channel/downstream backpressure and an outstanding-read limit.
module fft_rd_engine
  import fft_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned CNT_W           = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  t_hc_address          buf_addr,
  input  logic [31:0]          buf_size,
  input  logic                 tx_alm_full,
  input  logic                 out_alm_full,
  output logic                 rd_req_valid,
  output t_cl_addr             rd_req_addr,
  output logic [15:0]          rd_req_mdata,
  input  logic                 rsp_valid,
  input  logic [15:0]          rsp_mdata,
  input  t_block               rsp_data,
  output logic                 out_valid,
  output logic [15:0]          out_index,
  output t_block               out_block,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  localparam logic [CNT_W-1:0] MAX_OS = CNT_W'(MAX_OUTSTANDING);

  t_rd_state            state_q, state_d;
  t_cl_addr             base_cl_q, base_cl_d;
  logic [LINES_W-1:0]   lines_q, lines_d;
  logic [LINES_W-1:0]   issued_q, issued_d;
  logic [LINES_W-1:0]   received_q, received_d;
  logic [CNT_W-1:0]     outstanding_q, outstanding_d;
  logic                 abort_q, abort_d;
  logic                 req_valid_q, req_valid_d;
  t_cl_addr             req_addr_q, req_addr_d;
  logic [15:0]          req_mdata_q, req_mdata_d;
  logic                 out_valid_q;
  logic [15:0]          out_index_q;
  t_block               out_block_q;
  logic                 done_q, aborted_q;

  logic                 issue;
  logic                 rsp_accept;
  logic [LINES_W-1:0]   target;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{buf_addr[63:48], buf_addr[5:0]};
  assign rsp_accept       = rsp_valid && (state_q != S_RD_IDLE);
  // An aborted fetch only waits for the lines it actually requested.
  assign target           = abort_q ? issued_q : lines_q;

  always_comb begin
    state_d       = state_q;
    base_cl_d     = base_cl_q;
    lines_d       = lines_q;
    issued_d      = issued_q;
    received_d    = received_q;
    outstanding_d = outstanding_q;
    abort_d       = abort_q;
    req_valid_d   = 1'b0;
    req_addr_d    = req_addr_q;
    req_mdata_d   = req_mdata_q;
    issue         = 1'b0;

    unique case (state_q)
      S_RD_IDLE: begin
        if (start) begin
          base_cl_d     = buf_addr[47:6];
          lines_d       = hc_size_to_lines(buf_size);
          issued_d      = '0;
          received_d    = '0;
          outstanding_d = '0;
          abort_d       = 1'b0;
          state_d       = (hc_size_to_lines(buf_size) == '0) ? S_RD_FINISH : S_RD_FETCH;
        end
      end
      S_RD_FETCH: begin
        if (stop) begin
          abort_d = 1'b1;
          state_d = S_RD_WAIT;
        end else if (!tx_alm_full && !out_alm_full && (outstanding_q < MAX_OS)) begin
          issue       = 1'b1;
          req_valid_d = 1'b1;
          req_addr_d  = base_cl_q + t_cl_addr'(issued_q);
          req_mdata_d = issued_q[15:0];
          issued_d    = issued_q + 1'b1;
          if (issued_d == lines_q) state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (received_q == target) state_d = S_RD_FINISH;
      end
      S_RD_FINISH: state_d = S_RD_IDLE;
      default:     state_d = S_RD_IDLE;
    endcase

    if (rsp_accept) received_d = received_q + 1'b1;

    unique case ({issue, rsp_accept})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_RD_IDLE;
      base_cl_q     <= '0;
      lines_q       <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      abort_q       <= 1'b0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      req_mdata_q   <= '0;
      out_valid_q   <= 1'b0;
      out_index_q   <= '0;
      out_block_q   <= '0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_cl_q     <= base_cl_d;
      lines_q       <= lines_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      abort_q       <= abort_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      req_mdata_q   <= req_mdata_d;
      out_valid_q   <= rsp_accept;
      if (rsp_accept) begin
        out_index_q <= rsp_mdata;
        out_block_q <= rsp_data;
      end
      done_q        <= (state_q == S_RD_FINISH);
      aborted_q     <= (state_q == S_RD_FINISH) && abort_q;
    end
  end

  assign rd_req_valid = req_valid_q;
  assign rd_req_addr  = req_addr_q;
  assign rd_req_mdata = req_mdata_q;
  assign out_valid    = out_valid_q;
  assign out_index    = out_index_q;
  assign out_block    = out_block_q;
  assign busy         = (state_q != S_RD_IDLE);
  assign done         = done_q;
  assign aborted      = aborted_q;

endmodule
